frame_buffer: RTL

- Upstream neighbour of the window stage in frame_fft_block. Stores the incoming audio sample stream in a circular buffer and cuts it into overlapping frames of N samples, with a hop of HOP samples.
- Announces each complete frame with valid_packet. It then serves that frame one sample per request pulse on the window stage's valid_request/valid_in handshake.

---
 rtl/frame_fft_pkg.sv | 24 ++
 rtl/frame_ram.sv | 37 +++
 rtl/frame_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/frame_fft_pkg.sv
// rtl/frame_fft_pkg.sv - shared constants and types for the frame/window/FFT chain
package frame_fft_pkg;

  // Sample format: signed, SAMPLE_MSB+1 bits wide
  localparam int SAMPLE_MSB = 15;

  // Framing geometry
  localparam int FRAME_N   = 256;
  localparam int FRAME_HOP = 128;

  // Circular buffer geometry; BUF_DEPTH must be a power of two >= FRAME_N + FRAME_HOP
  localparam int BUF_DEPTH = 512;
  localparam int BUF_AW    = 9;

  typedef logic signed [SAMPLE_MSB:0] sample_t;

  // Frame buffer sequencing: wait for a frame, serve it, then slide the base by one hop
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    ADVANCE = 2'd2
  } fb_state_t;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port sample RAM, one write port and one registered read port
module frame_ram
  import frame_fft_pkg::*;
#(
  parameter int W     = SAMPLE_MSB + 1,
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data
);

  logic signed [W-1:0] mem [DEPTH];

  // Write port; contents are deliberately never cleared so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; the output register clears on reset and holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - circular sample buffer that cuts the stream into overlapping frames
module frame_buffer
  import frame_fft_pkg::*;
#(
  parameter int Q_IN  = SAMPLE_MSB,
  parameter int N     = FRAME_N,
  parameter int HOP   = FRAME_HOP,
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [Q_IN:0] sample_in,
  input  logic                 sample_valid,
  input  logic                 valid_request,
  output logic                 valid_packet,
  output logic                 valid_out,
  output logic signed [Q_IN:0] data_out,
  output logic                 overrun,
  output logic [15:0]          frame_count
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N_C     = (AW+1)'(N);
  localparam logic [AW:0]   N_LAST  = (AW+1)'(N - 1);
  localparam logic [AW:0]   HOP_C   = (AW+1)'(HOP);
  localparam logic [AW-1:0] HOP_A   = AW'(HOP);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  fb_state_t state, state_next;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_cnt;
  logic [AW:0]   avail;
  logic [AW:0]   avail_next;
  logic          req_d;

  logic          req_edge;
  logic          wr_accept;
  logic          wr_drop;
  logic          serve;
  logic          advance;
  logic [AW-1:0] rd_addr;

  // Only the rising edge of the level request serves a sample
  assign req_edge  = valid_request & ~req_d;
  assign wr_accept = sample_valid & (avail < DEPTH_C);
  assign wr_drop   = sample_valid & (avail == DEPTH_C);
  assign rd_addr   = rd_base + rd_cnt[AW-1:0];

  // Stored-sample count after this cycle: one hop is released on ADVANCE, one sample may land
  assign avail_next = avail - (advance ? HOP_C : '0) + (wr_accept ? ONE_C : '0);

  frame_ram #(
    .W     (Q_IN + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (sample_in),
    .rd_en   (serve),
    .rd_addr (rd_addr),
    .rd_data (data_out)
  );

  // Next-state and per-cycle strobes for the frame sequencer
  always_comb begin
    state_next = state;
    serve      = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (req_edge && valid_packet) begin
          serve      = 1'b1;
          state_next = (rd_cnt == N_LAST) ? ADVANCE : READ;
        end
      end
      READ: begin
        if (req_edge) begin
          serve = 1'b1;
          if (rd_cnt == N_LAST) begin
            state_next = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        advance    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request history for edge detection, updated every cycle regardless of state
  always_ff @(posedge clk) begin
    if (reset) begin
      req_d <= 1'b0;
    end else begin
      req_d <= valid_request;
    end
  end

  // Write pointer and sticky overrun flag; the write side ignores the sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ONE_A;
      end
      if (wr_drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Occupancy measured from rd_base
  always_ff @(posedge clk) begin
    if (reset) begin
      avail <= '0;
    end else begin
      avail <= avail_next;
    end
  end

  // Read base, in-frame index and completed-frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_base     <= '0;
      rd_cnt      <= '0;
      frame_count <= '0;
    end else if (advance) begin
      rd_base     <= rd_base + HOP_A;
      rd_cnt      <= '0;
      frame_count <= frame_count + 16'd1;
    end else if (serve) begin
      rd_cnt <= rd_cnt + ONE_C;
    end
  end

  // Frame-ready flag; ADVANCE looks ahead so a back-to-back frame is flagged in the first IDLE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_packet <= 1'b0;
    end else if (serve) begin
      valid_packet <= 1'b0;
    end else begin
      case (state)
        IDLE:    valid_packet <= (avail >= N_C);
        ADVANCE: valid_packet <= (avail_next >= N_C);
        default: valid_packet <= 1'b0;
      endcase
    end
  end

  // One-cycle strobe aligned with the registered RAM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= serve;
    end
  end

endmodule
